// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer, its FIFO and the bench.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned ALU_SEL_W = 3;
    localparam int unsigned ALU_RES_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [ALU_SEL_W-1:0] sel;
    } cmd_t;

    localparam logic [ALU_SEL_W-1:0] OP_ADD = 3'd0;
    localparam logic [ALU_SEL_W-1:0] OP_SUB = 3'd1;
    localparam logic [ALU_SEL_W-1:0] OP_AND = 3'd2;
    localparam logic [ALU_SEL_W-1:0] OP_OR  = 3'd3;
    localparam logic [ALU_SEL_W-1:0] OP_XOR = 3'd4;
    localparam logic [ALU_SEL_W-1:0] OP_MUL = 3'd5;
    localparam logic [ALU_SEL_W-1:0] OP_SHL = 3'd6;
    localparam logic [ALU_SEL_W-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with naturally wrapping pointers and an occupancy counter.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cmd_t                       din,
    input  logic                       pop,
    output cmd_t                       dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time and holds each tagged result until consumed.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SEL_W = ALU_SEL_W,
    parameter int unsigned RES_W = ALU_RES_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [SEL_W-1:0]           cmd_sel,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [RES_W-1:0]           alu_y,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RES_W-1:0]           res_y,
    output logic [TAG_W-1:0]           res_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    state_t           state;
    cmd_t             wr_cmd;
    cmd_t             head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] issue_tag;

    assign wr_cmd    = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    // Issue from IDLE, or straight from RESP on the edge the result is consumed.
    assign pop       = !empty && ((state == IDLE) || ((state == RESP) && res_ready));
    assign busy      = (state != IDLE) || !empty;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_cmd),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_y     <= '0;
            res_tag   <= '0;
            res_valid <= 1'b0;
            tag_cnt   <= '0;
            issue_tag <= '0;
        end else begin
            if (pop) begin
                alu_a     <= head.a;
                alu_b     <= head.b;
                alu_sel   <= head.sel;
                issue_tag <= tag_cnt;
                tag_cnt   <= tag_cnt + TAG_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pop) state <= EXEC;
                end
                EXEC: begin
                    res_y     <= alu_y;
                    res_tag   <= issue_tag;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU and an in-order result scoreboard.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_y;
    logic [3:0]  res_tag;
    logic [2:0]  count;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_ret   = 0;
    logic [15:0] exp_q [$];
    logic [3:0]  exp_tag = 4'd0;
    logic [7:0]  last_a;
    logic [7:0]  last_b;
    logic [2:0]  last_sel;

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_tag   (res_tag),
        .count     (count),
        .busy      (busy)
    );

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] s);
        case (s)
            OP_ADD:  return 16'(a) + 16'(b);
            OP_SUB:  return 16'(a) - 16'(b);
            OP_AND:  return 16'(a & b);
            OP_OR:   return 16'(a | b);
            OP_XOR:  return 16'(a ^ b);
            OP_MUL:  return 16'(a) * 16'(b);
            OP_SHL:  return 16'(a) << b[2:0];
            default: return 16'(a >> b[2:0]);
        endcase
    endfunction

    assign alu_y = alu_model(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; handshakes are sampled just before the edge and scored after it.
    task automatic tick();
        logic        pa, rt;
        logic [15:0] ry, py;
        logic [3:0]  rtg;
        pa  = cmd_valid && cmd_ready;
        rt  = res_valid && res_ready;
        ry  = res_y;
        rtg = res_tag;
        py  = alu_model(cmd_a, cmd_b, cmd_sel);
        @(posedge clk);
        #1;
        if (rt) begin
            n_ret++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'(1), 32'(0));
            end else begin
                chk("sb_res_y", 32'(ry), 32'(exp_q.pop_front()));
                chk("sb_res_tag", 32'(rtg), 32'(exp_tag));
                exp_tag = exp_tag + 4'd1;
            end
        end
        if (pa) exp_q.push_back(py);
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                            input bit rand_rr);
        logic acc;
        int   n;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        last_a    = a;
        last_b    = b;
        last_sel  = s;
        n         = 0;
        do begin
            if (rand_rr) res_ready = 1'($urandom_range(0, 1));
            acc = cmd_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 32'(0), 32'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'(0));
        chk("drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_alu_a", 32'(alu_a), 32'(0));

        // Reset while a command is executing.
        push_cmd(8'h11, 8'h22, OP_ADD, 1'b0);
        push_cmd(8'h33, 8'h44, OP_SUB, 1'b0);
        chk("mid_alu_a", 32'(alu_a), 32'h11);
        chk("mid_count", 32'(count), 32'(1));
        chk("mid_busy", 32'(busy), 32'(1));
        chk("mid_res_valid", 32'(res_valid), 32'(0));
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'(0));
        chk("async_res_valid", 32'(res_valid), 32'(0));
        chk("async_alu_a", 32'(alu_a), 32'(0));
        chk("async_res_tag", 32'(res_tag), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        exp_q.delete();
        exp_tag = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD: issued at E1, result visible after E2.
        push_cmd(8'h0F, 8'h03, OP_ADD, 1'b0);
        chk("single_count", 32'(count), 32'(1));
        chk("single_alu_a_pre", 32'(alu_a), 32'(0));
        tick();
        chk("single_alu_a", 32'(alu_a), 32'h0F);
        chk("single_alu_b", 32'(alu_b), 32'h03);
        chk("single_alu_sel", 32'(alu_sel), 32'(OP_ADD));
        chk("single_exec_valid", 32'(res_valid), 32'(0));
        chk("single_exec_count", 32'(count), 32'(0));
        tick();
        chk("single_res_valid", 32'(res_valid), 32'(1));
        chk("single_res_y", 32'(res_y), 32'h0012);
        chk("single_res_tag", 32'(res_tag), 32'(0));
        tick();
        chk("single_res_retired", 32'(res_valid), 32'(0));
        chk("single_idle_busy", 32'(busy), 32'(0));

        // Fill the FIFO under backpressure.
        res_ready = 1'b0;
        push_cmd(8'h05, 8'h07, OP_MUL, 1'b0);
        push_cmd(8'hF0, 8'h0F, OP_OR,  1'b0);
        push_cmd(8'h10, 8'h01, OP_SUB, 1'b0);
        push_cmd(8'h81, 8'h02, OP_SHL, 1'b0);
        push_cmd(8'hAA, 8'hFF, OP_XOR, 1'b0);
        chk("full_count", 32'(count), 32'(4));
        chk("full_cmd_ready", 32'(cmd_ready), 32'(0));
        chk("full_res_y", 32'(res_y), 32'h0023);
        chk("full_res_tag", 32'(res_tag), 32'(1));
        chk("full_alu_a", 32'(alu_a), 32'h05);
        cmd_valid = 1'b1;
        cmd_a     = 8'h03;
        cmd_b     = 8'h04;
        cmd_sel   = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_res_y", 32'(res_y), 32'h0023);
            chk("stall_res_valid", 32'(res_valid), 32'(1));
            chk("stall_count", 32'(count), 32'(4));
        end

        // One-cycle release: one result retired, next command issued on the same edge.
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rel_count", 32'(count), 32'(3));
        chk("rel_res_valid", 32'(res_valid), 32'(0));
        chk("rel_alu_a", 32'(alu_a), 32'hF0);
        tick();
        cmd_valid = 1'b0;
        chk("rel_push_count", 32'(count), 32'(4));
        chk("rel_res_y", 32'(res_y), 32'h00FF);
        chk("rel_res_tag", 32'(res_tag), 32'(2));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        chk("pp_pre_count", 32'(count), 32'(3));
        chk("pp_pre_res_y", 32'(res_y), 32'h000F);

        // Push and pop on the same edge keep occupancy.
        cmd_valid = 1'b1;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        cmd_sel   = OP_MUL;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("pp_count", 32'(count), 32'(3));
        chk("pp_alu_a", 32'(alu_a), 32'h81);
        drain();
        chk("full_ret_total", 32'(n_ret), 32'(8));

        // Random stream after reset: in-order results, tags 0..15,0..3.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_tag = 4'd0;
        n_ret   = 0;
        for (int i = 0; i < 20; i++) begin
            push_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
        end
        drain();
        chk("stream_ret_total", 32'(n_ret), 32'(20));
        chk("stream_tag_wrap", 32'(exp_tag), 32'(4));
        chk("stream_last_tag", 32'(res_tag), 32'(3));

        // Idle hold.
        repeat (10) tick();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_res_valid", 32'(res_valid), 32'(0));
        chk("idle_count", 32'(count), 32'(0));
        chk("idle_alu_a", 32'(alu_a), 32'(last_a));
        chk("idle_alu_b", 32'(alu_b), 32'(last_b));
        chk("idle_alu_sel", 32'(alu_sel), 32'(last_sel));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
